// File: rtl/tff_pkg.sv
// Shared constants and the direction encoding for the T-flip-flop modulo counter.
package tff_pkg;

  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_MODULUS = 10;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Legal modulus range is 2..2**width.
  function automatic bit modulus_ok(input int unsigned width, input int unsigned modulus);
    return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/tff_mod_counter_if.sv
// Control/status bundle between the modulo counter and the logic that drives it.
interface tff_mod_counter_if
  import tff_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             div_out;

    modport master (
        output en, up, load, load_val,
        input  count, tc, div_out
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, div_out
    );

endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop: synchronous active-high reset to 0, toggles when t is high.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter built from T flip-flop cells.
// Define TFF_MOD_COUNTER_DIV_OUT_EN to add the divide-by-2*MODULUS square-wave flop on div_out.
module tff_mod_counter
  import tff_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MODULUS = DEF_MODULUS
) (
    input logic          clk,
    input logic          rst,
    tff_mod_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("tff_mod_counter: MODULUS %0d outside 2..2**WIDTH (WIDTH=%0d)", MODULUS, WIDTH);
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] t_vec;
    dir_e             dir;
    logic             at_top;
    logic             at_bottom;
    logic             tc_c;

    always_comb begin
        dir        = dir_e'(bus.up);
        at_top     = (count_q == MAX_CNT);
        at_bottom  = &count_n;
        next_count = count_q;

        if (bus.load) begin
            next_count = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : MAX_CNT;
        end else if (bus.en) begin
            if (dir == DIR_UP) begin
                next_count = at_top ? '0 : count_q + WIDTH'(1);
            end else begin
                next_count = at_bottom ? MAX_CNT : count_q - WIDTH'(1);
            end
        end

        // Cells only ever see a toggle request; the target value is reached by flipping differing bits.
        t_vec = count_q ^ next_count;

        tc_c = bus.en & ~bus.load &
               (((dir == DIR_UP) & at_top) | ((dir == DIR_DOWN) & at_bottom));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .t     (t_vec[i]),
            .q     (count_q[i]),
            .q_bar (count_n[i])
        );
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_c;

`ifdef TFF_MOD_COUNTER_DIV_OUT_EN
    logic div_q;
    logic div_n;

    tff_cell u_div_cell (
        .clk   (clk),
        .rst   (rst),
        .t     (tc_c),
        .q     (div_q),
        .q_bar (div_n)
    );

    assign bus.div_out = div_q & ~div_n;
`else
    assign bus.div_out = 1'b0;
`endif

endmodule
